// File: rtl/tile_link_arb_pkg.sv
// Shared tile definitions: beat width, requester indices, arbiter states and
// the wrreq header field placement used by the link arbiter and ring FIFOs.
package tile_link_arb_pkg;

   localparam int TILE_W = 731;
   localparam int NREQ   = 3;

   localparam logic [1:0] REQ_LOCAL = 2'd0;
   localparam logic [1:0] REQ_PASS  = 2'd1;
   localparam logic [1:0] REQ_MISS  = 2'd2;

   typedef enum logic [1:0] {IDLE, GRANT, STALL} arb_state_t;

   // wrreq header fields carrying the source tile coordinates
   localparam int WR_TY_LSB = 0;
   localparam int WR_TY_W   = 4;
   localparam int WR_TX_LSB = 4;
   localparam int WR_TX_W   = 4;

   function automatic logic [1:0] rr_next(input logic [1:0] p);
      return (p >= 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

endpackage

// File: rtl/tile_link_arb_pick.sv
// Three-way round-robin picker: first requester at or after ptr+1 (mod 3).
module rr_pick3
   import tile_link_arb_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   output logic [2:0] gnt,
   output logic [1:0] idx
);

   logic [1:0] c0, c1, c2;

   assign c0 = rr_next(ptr);
   assign c1 = rr_next(c0);
   assign c2 = rr_next(c1);

   always_comb begin
      idx = c0;
      if (req[c0])      idx = c0;
      else if (req[c1]) idx = c1;
      else if (req[c2]) idx = c2;
      gnt = (|req) ? (3'b001 << idx) : 3'b000;
   end

endmodule

// File: rtl/tile_link_arb.sv
// Credit-based arbiter of three beat sources onto the outgoing ring link,
// with multi-beat locks and a bounded wait for the pass-through requester.
module tile_link_arb
   import tile_link_arb_pkg::*;
#(
   parameter int tile_X  = 0,
   parameter int tile_Y  = 0,
   parameter int CREDITS = 8,
   parameter int W       = TILE_W
)(
   input  logic           clk,
   input  logic           rst,
   input  logic [2:0]     req_valid,
   input  logic [3*W-1:0] req_data,
   input  logic [2:0]     req_lock,
   output logic [2:0]     req_ready,
   input  logic           credit_ret,
   output logic           link_valid,
   output logic [W-1:0]   link_data,
   output logic [1:0]     link_src,
   output logic [3:0]     credits,
   output logic           credit_err
);

   localparam logic [3:0] CRED_MAX = 4'(CREDITS);
   localparam logic [4:0] HOLD_MAX = 5'(2*CREDITS-1);

   arb_state_t state;
   logic [1:0] win, rr_ptr, cur, pick_idx;
   logic [2:0] pick_gnt, cur_oh;
   logic [4:0] hold_cnt, next_hold;
   logic       has_cred, xfer, force_rel, keep;
   logic [W-1:0] beat;

   rr_pick3 u_pick (.req(req_valid), .ptr(rr_ptr), .gnt(pick_gnt), .idx(pick_idx));

   assign cur      = (state == IDLE) ? pick_idx : win;
   assign cur_oh   = (state == IDLE) ? pick_gnt : (3'b001 << win);
   assign has_cred = (credits != 4'd0);

   assign req_ready = (!rst && state != STALL && has_cred) ? (cur_oh & req_valid) : 3'b000;
   assign xfer      = |(req_valid & req_ready);

   // A waiting pass-through requester breaks any other requester's lock once
   // it has sat through 2*CREDITS locked beats.
   assign force_rel = (cur != REQ_PASS) && req_valid[REQ_PASS] && (hold_cnt == HOLD_MAX);
   assign keep      = req_lock[cur] && !force_rel;
   assign next_hold = (cur != REQ_PASS && req_valid[REQ_PASS]) ? hold_cnt + 5'd1 : 5'd0;

   always_comb begin
      beat = req_data[int'(cur)*W +: W];
      if (cur == REQ_LOCAL) begin
         beat[WR_TX_LSB +: WR_TX_W] = WR_TX_W'(tile_X);
         beat[WR_TY_LSB +: WR_TY_W] = WR_TY_W'(tile_Y);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         win        <= 2'd0;
         rr_ptr     <= 2'd2;
         hold_cnt   <= 5'd0;
         credits    <= CRED_MAX;
         credit_err <= 1'b0;
         link_valid <= 1'b0;
         link_data  <= '0;
         link_src   <= 2'd0;
      end else begin
         link_valid <= xfer;
         if (xfer) begin
            link_data <= beat;
            link_src  <= cur;
         end

         case ({xfer, credit_ret})
            2'b10:   credits <= credits - 4'd1;
            2'b01:   if (credits == CRED_MAX) credit_err <= 1'b1;
                     else                     credits    <= credits + 4'd1;
            default: ;
         endcase

         case (state)
            IDLE: if (|req_valid) begin
               win <= pick_idx;
               if (!has_cred) state <= STALL;
               else if (keep) begin
                  state    <= GRANT;
                  hold_cnt <= next_hold;
               end else begin
                  rr_ptr   <= force_rel ? REQ_LOCAL : pick_idx;
                  hold_cnt <= 5'd0;
               end
            end
            GRANT: if (!req_valid[win]) begin
               state    <= IDLE;
               hold_cnt <= 5'd0;
            end else if (!has_cred) begin
               state <= STALL;
            end else if (keep) begin
               hold_cnt <= next_hold;
            end else begin
               // forced release points rr_ptr just before the pass-through requester
               state    <= IDLE;
               rr_ptr   <= force_rel ? REQ_LOCAL : win;
               hold_cnt <= 5'd0;
            end
            STALL: if (!req_valid[win]) begin
               state    <= IDLE;
               hold_cnt <= 5'd0;
            end else if (has_cred || credit_ret) begin
               state <= GRANT;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tile_link_arb.sv
// Directed bench for tile_link_arb: cycle table plus stall, reset and lock-limit sequences.
module tb_tile_link_arb;
   import tile_link_arb_pkg::*;

   localparam int W  = TILE_W;
   localparam int TX = 3;
   localparam int TY = 5;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [2:0]     req_valid = '0, req_lock = '0, req_ready;
   logic [3*W-1:0] req_data = '0;
   logic           credit_ret = 1'b0;
   logic           link_valid, credit_err;
   logic [W-1:0]   link_data;
   logic [1:0]     link_src;
   logic [3:0]     credits;

   int errors = 0;
   int checks = 0;

   tile_link_arb #(.tile_X(TX), .tile_Y(TY), .CREDITS(8), .W(W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_lock(req_lock), .req_ready(req_ready), .credit_ret(credit_ret),
      .link_valid(link_valid), .link_data(link_data), .link_src(link_src),
      .credits(credits), .credit_err(credit_err));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [W-1:0] mk(input int k);
      logic [32*23-1:0] t;
      t = {23{32'hA5C3_0000 + 32'(k) * 32'h0101_0137}};
      return t[W-1:0];
   endfunction

   function automatic logic [W-1:0] exp_beat(input int k, input logic [1:0] src);
      logic [W-1:0] d;
      d = mk(k);
      if (src == 2'd0) begin
         d[7:4] = 4'(TX);
         d[3:0] = 4'(TY);
      end
      return d;
   endfunction

   task automatic set_data(input int base);
      req_data = {mk(base + 2), mk(base + 1), mk(base)};
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_data(input string nm, input logic [W-1:0] exp);
      checks++;
      if (link_data !== exp) begin
         errors++;
         $display("FAIL %s: got low %h want low %h", nm, link_data[31:0], exp[31:0]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [2:0] v;
      logic [2:0] lk;
      logic       cr;
      logic [2:0] rdy;
      logic       lv;
      logic [1:0] src;
      logic [3:0] cred;
      logic       err;
   } vec_t;

   vec_t tbl[20];
   int   sent, cnt;
   logic saw, multi;

   initial begin
      // v, lock, credit_ret | ready now | link_valid, link_src, credits, credit_err seen this cycle
      tbl[0]  = '{3'b111, 3'b000, 1'b0, 3'b001, 1'b0, 2'd0, 4'd8, 1'b0};
      tbl[1]  = '{3'b111, 3'b000, 1'b0, 3'b010, 1'b1, 2'd0, 4'd7, 1'b0};
      tbl[2]  = '{3'b111, 3'b000, 1'b0, 3'b100, 1'b1, 2'd1, 4'd6, 1'b0};
      tbl[3]  = '{3'b111, 3'b000, 1'b0, 3'b001, 1'b1, 2'd2, 4'd5, 1'b0};
      tbl[4]  = '{3'b111, 3'b000, 1'b0, 3'b010, 1'b1, 2'd0, 4'd4, 1'b0};
      tbl[5]  = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b1, 2'd1, 4'd3, 1'b0};
      tbl[6]  = '{3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 2'd0, 4'd3, 1'b0};
      tbl[7]  = '{3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 2'd0, 4'd4, 1'b0};
      tbl[8]  = '{3'b100, 3'b000, 1'b1, 3'b100, 1'b0, 2'd0, 4'd5, 1'b0};
      tbl[9]  = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b1, 2'd2, 4'd5, 1'b0};
      tbl[10] = '{3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 2'd0, 4'd5, 1'b0};
      tbl[11] = '{3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 2'd0, 4'd6, 1'b0};
      tbl[12] = '{3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 2'd0, 4'd7, 1'b0};
      tbl[13] = '{3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 2'd0, 4'd8, 1'b0};
      tbl[14] = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 2'd0, 4'd8, 1'b1};
      tbl[15] = '{3'b010, 3'b010, 1'b0, 3'b010, 1'b0, 2'd0, 4'd8, 1'b1};
      tbl[16] = '{3'b011, 3'b010, 1'b0, 3'b010, 1'b1, 2'd1, 4'd7, 1'b1};
      tbl[17] = '{3'b011, 3'b000, 1'b0, 3'b010, 1'b1, 2'd1, 4'd6, 1'b1};
      tbl[18] = '{3'b011, 3'b000, 1'b0, 3'b001, 1'b1, 2'd1, 4'd5, 1'b1};
      tbl[19] = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b1, 2'd0, 4'd4, 1'b1};

      // reset state, with requests present to show ready is held low
      req_valid = 3'b111;
      @(negedge clk);
      chk("rst_ready", req_ready, 3'b000);
      chk("rst_link_valid", link_valid, 1'b0);
      chk("rst_credits", credits, 4'd8);
      chk("rst_credit_err", credit_err, 1'b0);
      chk("rst_link_src", link_src, 2'd0);
      chk("rst_link_data", 64'(link_data == '0), 1);
      step();
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         req_valid  = tbl[i].v;
         req_lock   = tbl[i].lk;
         credit_ret = tbl[i].cr;
         set_data(i * 3);
         @(negedge clk);
         chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].rdy);
         chk($sformatf("tbl%0d_link_valid", i), link_valid, tbl[i].lv);
         chk($sformatf("tbl%0d_credits", i), credits, tbl[i].cred);
         chk($sformatf("tbl%0d_credit_err", i), credit_err, tbl[i].err);
         if (tbl[i].lv) begin
            chk($sformatf("tbl%0d_link_src", i), link_src, tbl[i].src);
            chk_data($sformatf("tbl%0d_link_data", i), exp_beat((i - 1) * 3 + int'(tbl[i].src), tbl[i].src));
         end
         step();
      end

      // requester 0 alone runs out of credits, stalls, resumes on one credit
      req_valid = '0; req_lock = '0; credit_ret = 1'b0;
      rst = 1'b1;
      #2;
      chk("rerst_credit_err", credit_err, 1'b0);
      chk("rerst_credits", credits, 4'd8);
      step();
      rst = 1'b0;
      set_data(100);
      req_valid = 3'b001;
      sent = 0;
      repeat (9) begin
         @(negedge clk);
         if (req_ready[0]) sent++;
         step();
      end
      chk("stall_beats_sent", sent, 8);
      @(negedge clk);
      chk("stall_ready", req_ready, 3'b000);
      chk("stall_credits", credits, 4'd0);
      step();
      credit_ret = 1'b1;
      @(negedge clk);
      chk("stall_ready_on_ret", req_ready, 3'b000);
      step();
      credit_ret = 1'b0;
      @(negedge clk);
      chk("beat9_not_early", link_valid, 1'b0);
      chk("beat9_ready", req_ready, 3'b001);
      step();
      @(negedge clk);
      chk("beat9_link_valid", link_valid, 1'b1);
      chk("beat9_link_src", link_src, 2'd0);
      chk("beat9_credits", credits, 4'd0);
      chk_data("beat9_link_data", exp_beat(100, 2'd0));
      step();
      @(negedge clk);
      chk("stall2_ready", req_ready, 3'b000);

      // reset while stalled at zero credits
      #1;
      rst = 1'b1;
      #1;
      chk("stallrst_credits", credits, 4'd8);
      chk("stallrst_ready", req_ready, 3'b000);
      chk("stallrst_link_valid", link_valid, 1'b0);
      chk("stallrst_link_src", link_src, 2'd0);
      chk("stallrst_link_data", 64'(link_data == '0), 1);
      step();
      rst = 1'b0;
      req_valid = 3'b111;
      @(negedge clk);
      chk("postrst_first_grant", req_ready, 3'b001);
      step();
      chk("inflight_link_valid", link_valid, 1'b1);
      rst = 1'b1;
      #1;
      chk("inflight_rst_link_valid", link_valid, 1'b0);
      step();
      rst = 1'b0;

      // requester 2 locked while pass-through waits
      set_data(200);
      req_valid  = 3'b100;
      req_lock   = 3'b100;
      credit_ret = 1'b1;
      step();
      req_valid = 3'b110;
      cnt = 0; saw = 1'b0; multi = 1'b0;
      for (int c = 0; c < 40 && !saw; c++) begin
         @(negedge clk);
         if ($countones(req_ready) > 1) multi = 1'b1;
         if (req_ready[1]) saw = 1'b1;
         else if (req_ready[2]) cnt++;
         step();
      end
      chk("lock_limit_pass_granted", saw, 1'b1);
      chk("lock_limit_at_most_16", 64'(cnt <= 16), 1);
      chk("lock_limit_lock_honoured", 64'(cnt >= 2), 1);
      chk("lock_limit_onehot", multi, 1'b0);
      req_valid = '0; req_lock = '0; credit_ret = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tile_link_arb.md
TILE_LINK_ARB -- requirements
Module: tile_link_arb

Interface
REQ-001 Parameter tile_X, default 0: tile X coordinate; the link header TX field is driven from it for locally sourced beats.
REQ-002 Parameter tile_Y, default 0: tile Y coordinate; the link header TY field is driven from it.
REQ-003 Parameter CREDITS, default 8: downstream queue depth, range 1..15.
REQ-004 Parameter W, default 731: beat payload width, identical to the wrreq record width.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req_valid  in  3  requester has a beat; 0=local inject, 1=ring pass-through, 2=miss-issue/address forward.
REQ-008 req_data  in  3xW  beat payload per requester.
REQ-009 req_lock  in  3  requester keeps the grant after the current beat (multi-beat transfer).
REQ-010 req_ready  out  3  beat accepted this cycle; combinational.
REQ-011 credit_ret  in  1  downstream freed one slot.
REQ-012 link_valid  out  1  registered beat valid on the outgoing ring link (drives the snd bit).
REQ-013 link_data  out  W  registered beat payload.
REQ-014 link_src  out  2  index of the requester that sourced link_data.
REQ-015 credits  out  4  current credit count.
REQ-016 credit_err  out  1  sticky flag: credit returned while the count was already at CREDITS.

Function
REQ-017 The FSM SHALL have three states: IDLE, GRANT and STALL.
REQ-018 IDLE: no grant is held; on any req_valid the FSM selects the winner by round-robin starting at rr_ptr+1 mod 3.
REQ-019 Selection: with credits>0 the FSM goes to GRANT; with credits==0 it goes to STALL.
REQ-020 Handshake: req_ready[i] SHALL be 1 only when i is the current or selected winner, req_valid[i]=1 and credits>0; a transfer occurs when req_valid & req_ready.
REQ-021 Transfer timing: on a transfer, link_valid=1, link_data=req_data[i] and link_src=i SHALL appear the next cycle (latency 1); otherwise link_valid=0 and link_data holds its value.
REQ-022 GRANT: after a transfer with req_lock[i]=1 the grant is held; with req_lock[i]=0 rr_ptr<=i and the FSM returns to IDLE, or re-arbitrates in the same cycle if other req_valid bits are set.
REQ-023 Credits exhausted: when a held grant meets credits==0, the FSM goes to STALL and keeps the winner.
REQ-024 STALL: the winner is kept; req_ready=0; on credits>0 the FSM returns to GRANT.
REQ-025 Winner withdrawn: if the winner drops req_valid in STALL, the FSM returns to IDLE and rr_ptr is unchanged.
REQ-026 Credit arithmetic: credits <= credits - transfer + credit_ret, saturating at 0 and CREDITS.
REQ-027 Simultaneous transfer and credit_ret SHALL leave credits unchanged.
REQ-028 A credit_ret at credits==CREDITS with no transfer SHALL be ignored and set credit_err.
REQ-029 Pass-through lock limit: requester 1 SHALL never be blocked longer than 2*CREDITS consecutive locked beats of another requester.
REQ-030 The limit of REQ-029 is enforced by a 5-bit hold counter; when it expires with req_valid[1]=1, the lock is forcibly released and a locked requester 0 or 2 loses its grant.
REQ-031 At most one req_ready bit SHALL be high in any cycle.

Reset
REQ-032 On rst the block SHALL set state=IDLE, rr_ptr=2 (so requester 0 wins first), credits=CREDITS, link_valid=0, link_data=0, link_src=0, credit_err=0, hold counter=0, req_ready=0.
REQ-033 Reset asserted mid-transfer SHALL discard the in-flight beat; link_valid is 0 immediately, asynchronously.

Structure
REQ-034 The W and requester-index constants, the state enumeration and the wrreq field ranges SHALL live in the shared tile package used by the ring FIFOs.
REQ-035 The round-robin picker SHALL be one sub-module, rr_pick3: inputs req[2:0] and ptr[1:0], outputs a one-hot grant and an index.

Verification
REQ-036 After reset, req_valid=3'b111 with no locks -> grants 0,1,2,0 in consecutive cycles, link_valid high each cycle; credits falls 8,7,6,5,4.
REQ-037 Requester 0 alone for 9 beats with no credit_ret -> 8 beats sent, then STALL with req_ready=0; one credit_ret -> 9th beat appears 2 cycles later.
REQ-038 Requester 2 locked continuously while req_valid[1]=1 -> requester 1 is granted at latest after 16 beats of requester 2.
REQ-039 Transfer and credit_ret in the same cycle at credits=5 -> credits stays 5; credit_ret at credits=8 -> credits stays 8, credit_err=1 until reset.
REQ-040 rst pulsed while in STALL with credits=0 -> outputs go immediately to REQ-032 values, credits=8, next grant goes to requester 0.
